bu2020_memory: RTL and testbench

Memory responder for the BU2020 pipelined core: serves the core's instruction fetch port and its bidirectional data-memory bus, the slave end of both interfaces. After reset it holds the core off while a byte-serial boot loader fills instruction memory. It then answers fetches and loads combinationally and commits stores on the clock edge. It sits beside the core at top level, wired port-for-port to the core's memory and instruction buses.

---
 rtl/bu2020_pkg.sv | 16 +
 rtl/bu2020_boot_loader.sv | 118 +++++++++++
 rtl/bu2020_memory.sv | 123 ++++++++++++
 tb/tb_bu2020_memory.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bu2020_pkg.sv
// bu2020_pkg: shared widths, the MMIO address and the boot-loader state type
// for the BU2020 memory responder.
package bu2020_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 16;

    localparam logic [ADDR_W-1:0] MMIO_ADDR = 12'hFFF;

    typedef enum logic [1:0] {
        LOAD_LO,
        LOAD_HI,
        RUN
    } load_state_t;

endpackage

// File: rtl/bu2020_boot_loader.sv
// bu2020_boot_loader: byte-serial boot loader that fills instruction memory
// after reset and then releases the core.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   load_valid        boot byte present on load_data
//   load_data[7:0]    boot byte, little-endian (low byte first)
//   load_done         end-of-image strobe
//   load_ready        loader accepts a byte this cycle (registered)
//   cpu_hold          core held in reset while loading (registered)
//   words_loaded      number of instruction words written
//   running           FSM is in RUN
//   imem_we/waddr/wdata  instruction memory write port (commits on posedge)
//
// state   | meaning
// --------+----------------------------------------------------------
// LOAD_LO | waiting for the low byte of the next word
// LOAD_HI | low byte latched, waiting for the high byte
// RUN     | image complete; memory serves the core until rst
module bu2020_boot_loader
    import bu2020_pkg::*;
#(
    parameter int IMEM_DEPTH = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_valid,
    input  logic [7:0]        load_data,
    input  logic              load_done,
    output logic              load_ready,
    output logic              cpu_hold,
    output logic [12:0]       words_loaded,
    output logic              running,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [DATA_W-1:0] imem_wdata
);

    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(IMEM_DEPTH - 1);

    load_state_t       state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [7:0]        lo_q, lo_d;
    logic [12:0]       words_q, words_d;
    logic              load_ready_q, cpu_hold_q;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        lo_d       = lo_q;
        words_d    = words_q;
        imem_we    = 1'b0;
        imem_wdata = {load_data, lo_q};

        case (state_q)
            LOAD_LO: begin
                if (load_valid) begin
                    lo_d = load_data;
                    if (load_done) begin
                        // a lone low byte at end of image is zero-padded
                        imem_we    = 1'b1;
                        imem_wdata = {8'h00, load_data};
                        state_d    = RUN;
                    end else begin
                        state_d = LOAD_HI;
                    end
                end else if (load_done) begin
                    state_d = RUN;
                end
            end
            LOAD_HI: begin
                if (load_valid || load_done) begin
                    imem_we    = 1'b1;
                    imem_wdata = load_valid ? {load_data, lo_q} : {8'h00, lo_q};
                    state_d    = load_done ? RUN : LOAD_LO;
                end
            end
            RUN: begin
            end
            default: state_d = LOAD_LO;
        endcase

        if (imem_we) begin
            words_d = words_q + 13'd1;
            // the last word ends the load; the pointer is never allowed to wrap
            if (ptr_q == LAST_PTR) begin
                state_d = RUN;
            end else begin
                ptr_d = ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= LOAD_LO;
            ptr_q        <= '0;
            lo_q         <= '0;
            words_q      <= '0;
            load_ready_q <= 1'b1;
            cpu_hold_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            lo_q         <= lo_d;
            words_q      <= words_d;
            load_ready_q <= (state_d != RUN);
            cpu_hold_q   <= (state_d != RUN);
        end
    end

    assign load_ready   = load_ready_q;
    assign cpu_hold     = cpu_hold_q;
    assign words_loaded = words_q;
    assign running      = (state_q == RUN);
    assign imem_waddr   = ptr_q;

endmodule

// File: rtl/bu2020_memory.sv
// bu2020_memory: instruction and data memory responder for the BU2020 core.
// Holds the core off while the boot loader fills instruction memory, then
// serves fetches and loads combinationally and commits stores on posedge.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   Instruction_addressbus   fetch word address
//   Instruction_databus      fetched word (0 while loading)
//   Memory_addressbus        data word address
//   Memory_databus           bidirectional data bus (driven only on RUN loads)
//   Memory_writemode         1 = store, 0 = load
//   load_valid/data/done     boot byte stream
//   load_ready, cpu_hold     loader handshake / core hold
//   words_loaded             instruction words written by the loader
//   mmio_out                 memory-mapped output register
//
// Optional feature macro: BU2020_MEM_MMIO_EN maps address 12'hFFF to
// mmio_out; without it mmio_out is 0 and 12'hFFF is ordinary data memory.
module bu2020_memory
    import bu2020_pkg::*;
#(
    parameter int IMEM_DEPTH = 4096,
    parameter int DMEM_DEPTH = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] Instruction_addressbus,
    output logic [DATA_W-1:0] Instruction_databus,
    input  logic [ADDR_W-1:0] Memory_addressbus,
    inout  wire  [DATA_W-1:0] Memory_databus,
    input  logic              Memory_writemode,
    input  logic              load_valid,
    input  logic [7:0]        load_data,
    input  logic              load_done,
    output logic              load_ready,
    output logic              cpu_hold,
    output logic [12:0]       words_loaded,
    output logic [DATA_W-1:0] mmio_out
);

    localparam int IAW = $clog2(IMEM_DEPTH);
    localparam int DAW = $clog2(DMEM_DEPTH);

    logic [DATA_W-1:0] imem_mem [IMEM_DEPTH];
    logic [DATA_W-1:0] dmem_mem [DMEM_DEPTH];

    logic              running;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [DATA_W-1:0] imem_wdata;
    logic              store_en;
    logic              mmio_hit;
    logic [DATA_W-1:0] mmio_val;
    logic [DATA_W-1:0] rd_data;

    bu2020_boot_loader #(
        .IMEM_DEPTH (IMEM_DEPTH)
    ) u_boot_loader (
        .clk          (clk),
        .rst          (rst),
        .load_valid   (load_valid),
        .load_data    (load_data),
        .load_done    (load_done),
        .load_ready   (load_ready),
        .cpu_hold     (cpu_hold),
        .words_loaded (words_loaded),
        .running      (running),
        .imem_we      (imem_we),
        .imem_waddr   (imem_waddr),
        .imem_wdata   (imem_wdata)
    );

    // arrays carry no reset; contents survive rst
    always_ff @(posedge clk) begin
        if (imem_we && !rst) begin
            imem_mem[imem_waddr[IAW-1:0]] <= imem_wdata;
        end
    end

    assign store_en = running && Memory_writemode && !rst;

    always_ff @(posedge clk) begin
        if (store_en && !mmio_hit) begin
            dmem_mem[Memory_addressbus[DAW-1:0]] <= Memory_databus;
        end
    end

`ifdef BU2020_MEM_MMIO_EN
    logic [DATA_W-1:0] mmio_q, mmio_d;

    assign mmio_hit = (Memory_addressbus == MMIO_ADDR);

    always_comb begin
        mmio_d = mmio_q;
        if (store_en && mmio_hit) begin
            mmio_d = Memory_databus;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mmio_q <= '0;
        end else begin
            mmio_q <= mmio_d;
        end
    end

    assign mmio_val = mmio_q;
`else
    assign mmio_hit = 1'b0;
    assign mmio_val = '0;
`endif

    assign mmio_out = mmio_val;

    assign Instruction_databus = running ? imem_mem[Instruction_addressbus[IAW-1:0]] : '0;

    assign rd_data = mmio_hit ? mmio_val : dmem_mem[Memory_addressbus[DAW-1:0]];

    // the core owns the bus whenever it stores or while we are still loading
    assign Memory_databus = (running && !Memory_writemode) ? rd_data : 'z;

endmodule

// File: tb/tb_bu2020_memory.sv
module tb_bu2020_memory;

    logic        clk;
    logic        rst;
    logic [11:0] Instruction_addressbus;
    logic [15:0] Instruction_databus;
    logic [11:0] Memory_addressbus;
    wire  [15:0] Memory_databus;
    logic        Memory_writemode;
    logic        load_valid;
    logic [7:0]  load_data;
    logic        load_done;
    logic        load_ready;
    logic        cpu_hold;
    logic [12:0] words_loaded;
    logic [15:0] mmio_out;

    logic [15:0] tb_drv;
    logic        tb_en;
    assign Memory_databus = tb_en ? tb_drv : 16'hzzzz;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];
    logic [15:0] exp_v;

    bu2020_memory dut (
        .clk                    (clk),
        .rst                    (rst),
        .Instruction_addressbus (Instruction_addressbus),
        .Instruction_databus    (Instruction_databus),
        .Memory_addressbus      (Memory_addressbus),
        .Memory_databus         (Memory_databus),
        .Memory_writemode       (Memory_writemode),
        .load_valid             (load_valid),
        .load_data              (load_data),
        .load_done              (load_done),
        .load_ready             (load_ready),
        .cpu_hold               (cpu_hold),
        .words_loaded           (words_loaded),
        .mmio_out               (mmio_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic done);
        load_valid = 1'b1;
        load_data  = b;
        load_done  = done;
        tick();
        load_valid = 1'b0;
        load_done  = 1'b0;
    endtask

    task automatic pulse_done();
        load_done = 1'b1;
        tick();
        load_done = 1'b0;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic store(input logic [11:0] a, input logic [15:0] d);
        Memory_writemode  = 1'b1;
        Memory_addressbus = a;
        tb_en             = 1'b1;
        tb_drv            = d;
        tick();
        Memory_writemode  = 1'b0;
        tb_en             = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL reset_load_ready: got %0b want 1", load_ready); end
        checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL reset_cpu_hold: got %0b want 1", cpu_hold); end
        checks++; if (words_loaded !== 13'd0) begin errors++; $display("FAIL reset_words_loaded: got %0d want 0", words_loaded); end
        checks++; if (mmio_out !== 16'h0000) begin errors++; $display("FAIL reset_mmio_out: got %h want 0000", mmio_out); end
        rst = 1'b0;
        exp_q.push_back(16'h0000);
        Instruction_addressbus = 12'd0;
        #1;
        exp_v = exp_q.pop_front();
        checks++; if (Instruction_databus !== exp_v) begin errors++; $display("FAIL reset_fetch_zero: got %h want %h", Instruction_databus, exp_v); end
    endtask

    task automatic test_load_basic();
        send_byte(8'h34, 1'b0);
        send_byte(8'h12, 1'b0);
        send_byte(8'h78, 1'b0);
        send_byte(8'h56, 1'b0);
        checks++; if (words_loaded !== 13'd2) begin errors++; $display("FAIL basic_words: got %0d want 2", words_loaded); end
        checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL basic_hold_before_done: got %0b want 1", cpu_hold); end
        pulse_done();
        checks++; if (cpu_hold !== 1'b0) begin errors++; $display("FAIL basic_hold_after_done: got %0b want 0", cpu_hold); end
        checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL basic_ready_after_done: got %0b want 0", load_ready); end
        exp_q.push_back(16'h5678);
        Instruction_addressbus = 12'd1;
        #1;
        exp_v = exp_q.pop_front();
        checks++; if (Instruction_databus !== exp_v) begin errors++; $display("FAIL basic_fetch1: got %h want %h", Instruction_databus, exp_v); end
        exp_q.push_back(16'h1234);
        Instruction_addressbus = 12'd0;
        #1;
        exp_v = exp_q.pop_front();
        checks++; if (Instruction_databus !== exp_v) begin errors++; $display("FAIL basic_fetch0: got %h want %h", Instruction_databus, exp_v); end
    endtask

    task automatic test_store_load();
        Memory_writemode  = 1'b1;
        Memory_addressbus = 12'h010;
        tb_en             = 1'b1;
        tb_drv            = 16'hBEEF;
        exp_q.push_back(16'hBEEF);
        #1;
        exp_v = exp_q.pop_front();
        checks++; if (Memory_databus !== exp_v) begin errors++; $display("FAIL store_bus_value: got %h want %h", Memory_databus, exp_v); end
        tick();
        Memory_writemode = 1'b0;
        tb_en            = 1'b0;
        exp_q.push_back(16'hBEEF);
        #1;
        exp_v = exp_q.pop_front();
        checks++; if (Memory_databus !== exp_v) begin errors++; $display("FAIL load_after_store: got %h want %h", Memory_databus, exp_v); end
        // back-to-back stores followed by loads
        store(12'h030, 16'hA5A5);
        store(12'h031, 16'h5A5A);
        store(12'h020, 16'h1111);
        for (int i = 0; i < 3; i++) begin
            Memory_addressbus = (i == 0) ? 12'h030 : (i == 1) ? 12'h031 : 12'h020;
            exp_q.push_back((i == 0) ? 16'hA5A5 : (i == 1) ? 16'h5A5A : 16'h1111);
            #1;
            exp_v = exp_q.pop_front();
            checks++; if (Memory_databus !== exp_v) begin errors++; $display("FAIL b2b_load_%0d: got %h want %h", i, Memory_databus, exp_v); end
            tick();
        end
    endtask

    task automatic test_pad_and_blocked_store();
        pulse_rst();
        checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL pad_hold_after_rst: got %0b want 1", cpu_hold); end
        Instruction_addressbus = 12'd1;
        exp_q.push_back(16'h0000);
        Memory_writemode  = 1'b1;
        Memory_addressbus = 12'h020;
        tb_en             = 1'b1;
        tb_drv            = 16'h2222;
        #1;
        exp_v = exp_q.pop_front();
        checks++; if (Instruction_databus !== exp_v) begin errors++; $display("FAIL loading_fetch_zero: got %h want %h", Instruction_databus, exp_v); end
        tick();
        Memory_writemode = 1'b0;
        tb_en            = 1'b0;
        send_byte(8'hAB, 1'b0);
        send_byte(8'hCD, 1'b0);
        send_byte(8'hEF, 1'b1);
        checks++; if (words_loaded !== 13'd2) begin errors++; $display("FAIL pad_words: got %0d want 2", words_loaded); end
        checks++; if (cpu_hold !== 1'b0) begin errors++; $display("FAIL pad_hold: got %0b want 0", cpu_hold); end
        exp_q.push_back(16'hCDAB);
        exp_q.push_back(16'h00EF);
        for (int i = 0; i < 2; i++) begin
            Instruction_addressbus = 12'(i);
            #1;
            exp_v = exp_q.pop_front();
            checks++; if (Instruction_databus !== exp_v) begin errors++; $display("FAIL pad_fetch%0d: got %h want %h", i, Instruction_databus, exp_v); end
        end
        Memory_addressbus = 12'h020;
        exp_q.push_back(16'h1111);
        #1;
        exp_v = exp_q.pop_front();
        checks++; if (Memory_databus !== exp_v) begin errors++; $display("FAIL blocked_store: got %h want %h", Memory_databus, exp_v); end
    endtask

    task automatic test_reset_midload();
        pulse_rst();
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        checks++; if (words_loaded !== 13'd1) begin errors++; $display("FAIL midload_words: got %0d want 1", words_loaded); end
        pulse_rst();
        checks++; if (words_loaded !== 13'd0) begin errors++; $display("FAIL midload_words_rst: got %0d want 0", words_loaded); end
        send_byte(8'h44, 1'b0);
        send_byte(8'h55, 1'b0);
        checks++; if (words_loaded !== 13'd1) begin errors++; $display("FAIL reload_words: got %0d want 1", words_loaded); end
        checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL reload_hold: got %0b want 1", cpu_hold); end
        pulse_done();
        checks++; if (cpu_hold !== 1'b0) begin errors++; $display("FAIL reload_run: got %0b want 0", cpu_hold); end
        exp_q.push_back(16'h5544);
        exp_q.push_back(16'h00EF);
        for (int i = 0; i < 2; i++) begin
            Instruction_addressbus = 12'(i);
            #1;
            exp_v = exp_q.pop_front();
            checks++; if (Instruction_databus !== exp_v) begin errors++; $display("FAIL reload_fetch%0d: got %h want %h", i, Instruction_databus, exp_v); end
        end
    endtask

    task automatic test_mmio();
        store(12'hFFE, 16'h7777);
        store(12'hFFF, 16'h00A5);
`ifdef BU2020_MEM_MMIO_EN
        checks++; if (mmio_out !== 16'h00A5) begin errors++; $display("FAIL mmio_out: got %h want 00a5", mmio_out); end
`else
        checks++; if (mmio_out !== 16'h0000) begin errors++; $display("FAIL mmio_out: got %h want 0000", mmio_out); end
`endif
        Memory_addressbus = 12'hFFF;
        exp_q.push_back(16'h00A5);
        #1;
        exp_v = exp_q.pop_front();
        checks++; if (Memory_databus !== exp_v) begin errors++; $display("FAIL mmio_load: got %h want %h", Memory_databus, exp_v); end
        Memory_addressbus = 12'hFFE;
        exp_q.push_back(16'h7777);
        #1;
        exp_v = exp_q.pop_front();
        checks++; if (Memory_databus !== exp_v) begin errors++; $display("FAIL mmio_neighbour: got %h want %h", Memory_databus, exp_v); end
    endtask

    task automatic test_done_only();
        pulse_rst();
        pulse_done();
        checks++; if (cpu_hold !== 1'b0) begin errors++; $display("FAIL done_only_hold: got %0b want 0", cpu_hold); end
        checks++; if (words_loaded !== 13'd0) begin errors++; $display("FAIL done_only_words: got %0d want 0", words_loaded); end
        send_byte(8'h99, 1'b0);
        checks++; if (words_loaded !== 13'd0) begin errors++; $display("FAIL run_ignores_bytes: got %0d want 0", words_loaded); end
    endtask

    task automatic test_full_image();
        logic [15:0] w;
        pulse_rst();
        for (int i = 0; i < 4096; i++) begin
            w = 16'hA000 | 16'(i);
            send_byte(w[7:0], 1'b0);
            send_byte(w[15:8], 1'b0);
            if (i == 4094) begin
                checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL full_hold_early: got %0b want 1", cpu_hold); end
            end
        end
        checks++; if (cpu_hold !== 1'b0) begin errors++; $display("FAIL full_auto_run: got %0b want 0", cpu_hold); end
        checks++; if (words_loaded !== 13'd4096) begin errors++; $display("FAIL full_words: got %0d want 4096", words_loaded); end
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        checks++; if (words_loaded !== 13'd4096) begin errors++; $display("FAIL full_extra_words: got %0d want 4096", words_loaded); end
        for (int i = 0; i < 3; i++) begin
            Instruction_addressbus = (i == 0) ? 12'd0 : (i == 1) ? 12'd2048 : 12'd4095;
            exp_q.push_back(16'hA000 | 16'(Instruction_addressbus));
            #1;
            exp_v = exp_q.pop_front();
            checks++; if (Instruction_databus !== exp_v) begin errors++; $display("FAIL full_fetch_%0d: got %h want %h", i, Instruction_databus, exp_v); end
        end
    endtask

    initial begin
        rst                    = 1'b1;
        Instruction_addressbus = '0;
        Memory_addressbus      = '0;
        Memory_writemode       = 1'b0;
        load_valid             = 1'b0;
        load_data              = '0;
        load_done              = 1'b0;
        tb_en                  = 1'b0;
        tb_drv                 = '0;
        test_reset();
        test_load_basic();
        test_store_load();
        test_pad_and_blocked_store();
        test_reset_midload();
        test_mmio();
        test_done_only();
        test_full_image();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
